vita_tx_pkt_gate: RTL and testbench

Store-and-forward packet gate upstream of the VITA TX chain: accepts 36-bit host packets, buffers each packet whole, checks the VITA header length field against the actual word count, and releases only complete, well-formed packets on `data_o`. Malformed, truncated or oversized packets are discarded and counted, so the deframer never sees a partial packet and never stalls mid-packet on host starvation.

---
 rtl/vita_tx_pkt_gate_pkg.sv | 25 ++
 rtl/vita_tx_pkt_gate_pkt_buf_ram.sv | 24 ++
 rtl/vita_tx_pkt_gate.sv | 202 ++++++++++++++++++++
 tb/tb_vita_tx_pkt_gate.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vita_tx_pkt_gate_pkg.sv
// rtl/vita_tx_pkt_gate_pkg.sv - shared constants and types for the VITA TX packet gate
package vita_tx_pkt_gate_pkg;

   localparam int SOF_BIT = 32;
   localparam int EOF_BIT = 33;
   localparam int OCC_HI  = 35;
   localparam int OCC_LO  = 34;

   localparam logic [7:0] CTRL_OFS     = 8'd0;
   localparam logic [7:0] DROP_CLR_OFS = 8'd1;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_PKT  = 2'd1,
      W_DROP = 2'd2
   } wstate_t;

   // A single word can discard two packets at once (interrupted packet plus bad new header).
   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
      logic [16:0] s;
      s = {1'b0, a} + {15'b0, inc};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

endpackage

// File: rtl/vita_tx_pkt_gate_pkt_buf_ram.sv
// rtl/vita_tx_pkt_gate_pkt_buf_ram.sv - simple dual-port packet buffer, registered read
module pkt_buf_ram #(
   parameter int AW = 9,
   parameter int DW = 36
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      if (re)
         rdata <= mem[raddr];
   end

endmodule

// File: rtl/vita_tx_pkt_gate.sv
// rtl/vita_tx_pkt_gate.sv - store-and-forward gate releasing only complete, length-checked packets
module vita_tx_pkt_gate
   import vita_tx_pkt_gate_pkg::*;
#(
   parameter int BASE             = 0,
   parameter int BUF_SIZE         = 9,
   parameter int USE_TRANS_HEADER = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        set_stb,
   input  logic [7:0]  set_addr,
   input  logic [31:0] set_data,
   input  logic [35:0] data_i,
   input  logic        src_rdy_i,
   output logic        dst_rdy_o,
   output logic [35:0] data_o,
   output logic        src_rdy_o,
   input  logic        dst_rdy_i,
   output logic [15:0] drop_count,
   output logic [31:0] debug
);

   localparam logic [7:0]  CTRL_ADDR = 8'(BASE) + CTRL_OFS;
   localparam logic [7:0]  CLR_ADDR  = 8'(BASE) + DROP_CLR_OFS;
   localparam logic [16:0] MAX_TOTAL = 17'((1 << BUF_SIZE) - 1);
   localparam logic [16:0] TRANS     = 17'(USE_TRANS_HEADER);
   localparam logic [15:0] HDR_CNT   = 16'(USE_TRANS_HEADER + 1);

   typedef logic [BUF_SIZE-1:0] ptr_t;

   wstate_t     wstate, w_next;
   ptr_t        wr_ptr, wr_ptr_n, commit_ptr, commit_n, rd_ptr, ram_waddr, fill;
   logic [15:0] cnt, cnt_n;
   logic [16:0] exp_total, exp_n;
   logic        len_valid, lenv_n;
   logic [1:0]  drop_inc;
   logic        enable, ram_we, out_valid, advance, rd_issue, wr_fire, sof, eof;
   logic [35:0] ram_rdata;
   logic        unused_set_bits;

   assign wr_fire = src_rdy_i & dst_rdy_o;
   assign sof     = data_i[SOF_BIT];
   assign eof     = data_i[EOF_BIT];
   assign unused_set_bits = ^set_data[31:1];

   always_ff @(posedge clk) begin
      if (!reset)
         wstate <= W_IDLE;
      else if (clear)
         wstate <= W_IDLE;
      else
         wstate <= w_next;
   end

   always_comb begin : next_state
      ptr_t        base;
      logic [15:0] ncnt;
      logic        nlenv;
      logic [16:0] nexp;
      logic        bad_len;
      w_next    = wstate;
      wr_ptr_n  = wr_ptr;
      commit_n  = commit_ptr;
      cnt_n     = cnt;
      exp_n     = exp_total;
      lenv_n    = len_valid;
      drop_inc  = 2'd0;
      ram_we    = 1'b0;
      ram_waddr = wr_ptr;
      base      = wr_ptr;
      ncnt      = cnt + 16'd1;
      nlenv     = len_valid;
      nexp      = exp_total;
      bad_len   = 1'b0;
      if (wr_fire) begin
         case (wstate)
            W_DROP: begin
               if (eof)
                  w_next = W_IDLE;
            end
            default: begin
               if (wstate == W_IDLE && !sof) begin
                  drop_inc = 2'd1;
                  w_next   = eof ? W_IDLE : W_DROP;
               end else begin
                  // A SOF always restarts at the last commit point, abandoning any open packet.
                  if (sof) begin
                     base  = commit_ptr;
                     ncnt  = 16'd1;
                     nlenv = 1'b0;
                     if (wstate == W_PKT)
                        drop_inc = 2'd1;
                  end
                  ram_we    = 1'b1;
                  ram_waddr = base;
                  if (!nlenv && ncnt == HDR_CNT) begin
                     nlenv   = 1'b1;
                     nexp    = {1'b0, data_i[15:0]} + TRANS;
                     bad_len = (data_i[15:0] == 16'd0) || (nexp > MAX_TOTAL);
                  end
                  cnt_n  = ncnt;
                  lenv_n = nlenv;
                  exp_n  = nexp;
                  if (bad_len) begin
                     wr_ptr_n = commit_ptr;
                     drop_inc = drop_inc + 2'd1;
                     w_next   = eof ? W_IDLE : W_DROP;
                  end else if (eof) begin
                     if (nlenv && {1'b0, ncnt} == nexp) begin
                        commit_n = base + ptr_t'(1);
                        wr_ptr_n = base + ptr_t'(1);
                     end else begin
                        wr_ptr_n = commit_ptr;
                        drop_inc = drop_inc + 2'd1;
                     end
                     w_next = W_IDLE;
                  end else if (nlenv && {1'b0, ncnt} > nexp) begin
                     wr_ptr_n = commit_ptr;
                     drop_inc = drop_inc + 2'd1;
                     w_next   = W_DROP;
                  end else begin
                     wr_ptr_n = base + ptr_t'(1);
                     w_next   = W_PKT;
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      dst_rdy_o = 1'b0;
      case (wstate)
         W_DROP:  dst_rdy_o = enable;
         default: dst_rdy_o = enable && (wr_ptr + ptr_t'(1) != rd_ptr);
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         wr_ptr     <= '0;
         commit_ptr <= '0;
         cnt        <= '0;
         exp_total  <= '0;
         len_valid  <= 1'b0;
      end else begin
         wr_ptr     <= wr_ptr_n;
         commit_ptr <= commit_n;
         cnt        <= cnt_n;
         exp_total  <= exp_n;
         len_valid  <= lenv_n;
      end
   end

   // The RAM output register doubles as the output stage, giving fall-through after one read.
   assign advance  = !out_valid || dst_rdy_i;
   assign rd_issue = advance && (rd_ptr != commit_ptr);

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         rd_ptr    <= '0;
         out_valid <= 1'b0;
      end else begin
         if (rd_issue)
            rd_ptr <= rd_ptr + ptr_t'(1);
         if (advance)
            out_valid <= rd_issue;
      end
   end

   pkt_buf_ram #(.AW(BUF_SIZE), .DW(36)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (data_i),
      .re    (rd_issue),
      .raddr (rd_ptr),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         enable     <= 1'b0;
         drop_count <= '0;
      end else begin
         if (set_stb && set_addr == CTRL_ADDR)
            enable <= set_data[0];
         if (set_stb && set_addr == CLR_ADDR)
            drop_count <= '0;
         else if (!clear)
            drop_count <= sat_add(drop_count, drop_inc);
      end
   end

   assign src_rdy_o = out_valid;
   assign data_o    = out_valid ? ram_rdata : 36'd0;
   assign fill      = wr_ptr - rd_ptr;
   assign debug     = {wstate, 14'b0, 16'(fill)};

endmodule

// File: tb/tb_vita_tx_pkt_gate.sv
// tb/tb_vita_tx_pkt_gate.sv - directed self-checking bench for vita_tx_pkt_gate
module tb_vita_tx_pkt_gate;
   import vita_tx_pkt_gate_pkg::*;

   localparam int BUF    = 4;
   localparam int BASE_A = 16;

   logic        clk = 1'b0;
   logic        reset, clear, set_stb;
   logic [7:0]  set_addr;
   logic [31:0] set_data;
   logic [35:0] data_i;
   logic        src_rdy_i, dst_rdy_o;
   logic [35:0] data_o;
   logic        src_rdy_o, dst_rdy_i;
   logic [15:0] drop_count;
   logic [31:0] debug;

   int          checks = 0;
   int          errors = 0;
   logic [35:0] outq[$];
   logic [35:0] expq[$];
   logic [35:0] w;
   logic        rdy_all;

   vita_tx_pkt_gate #(.BASE(BASE_A), .BUF_SIZE(BUF), .USE_TRANS_HEADER(0)) dut (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .set_stb    (set_stb),
      .set_addr   (set_addr),
      .set_data   (set_data),
      .data_i     (data_i),
      .src_rdy_i  (src_rdy_i),
      .dst_rdy_o  (dst_rdy_o),
      .data_o     (data_o),
      .src_rdy_o  (src_rdy_o),
      .dst_rdy_i  (dst_rdy_i),
      .drop_count (drop_count),
      .debug      (debug)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (src_rdy_o && dst_rdy_i)
         outq.push_back(data_o);

   function automatic logic [35:0] mk(input logic sof, input logic eof, input logic [1:0] occ,
                                      input logic [31:0] pl);
      logic [35:0] r;
      r = '0;
      r[31:0] = pl;
      r[SOF_BIT] = sof;
      r[EOF_BIT] = eof;
      r[OCC_HI:OCC_LO] = occ;
      return r;
   endfunction

   function automatic logic [35:0] pw(input int k, input int len, input logic [7:0] tag,
                                      input logic last);
      logic [31:0] pl;
      if (k == 0)
         pl = {tag, 8'h00, 16'(len)};
      else
         pl = {tag, 8'(k), 16'hC0DE ^ 16'(k)};
      return mk(k == 0, last, last ? 2'b11 : 2'b01, pl);
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_reg(input int a, input logic [31:0] d);
      set_stb  = 1'b1;
      set_addr = 8'(a);
      set_data = d;
      tick(1);
      set_stb  = 1'b0;
   endtask

   task automatic send_word(input logic [35:0] wd);
      int t;
      t = 0;
      data_i = wd;
      src_rdy_i = 1'b1;
      while (!dst_rdy_o && t < 300) begin
         tick(1);
         t++;
      end
      if (t >= 300)
         check("send_timeout", 36'(t), 36'(0));
      tick(1);
      src_rdy_i = 1'b0;
   endtask

   task automatic send_pkt(input int len, input int n, input logic [7:0] tag,
                           input bit close, input bit keep);
      logic [35:0] x;
      for (int k = 0; k < n; k++) begin
         x = pw(k, len, tag, close && (k == n - 1));
         if (keep)
            expq.push_back(x);
         send_word(x);
      end
   endtask

   task automatic drain_and_compare(input string tag);
      int n, t;
      n = expq.size();
      t = 0;
      while (outq.size() < n && t < 500) begin
         tick(1);
         t++;
      end
      tick(3);
      check({tag, "_count"}, 36'(outq.size()), 36'(n));
      for (int i = 0; i < n && i < outq.size(); i++)
         check($sformatf("%s_word%0d", tag, i), outq[i], expq[i]);
      outq.delete();
      expq.delete();
   endtask

   initial begin
      reset = 1'b0; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
      data_i = '0; src_rdy_i = 1'b0; dst_rdy_i = 1'b1;
      tick(3);
      check("rst_dst_rdy", 36'(dst_rdy_o), 36'(0));
      check("rst_src_rdy", 36'(src_rdy_o), 36'(0));
      check("rst_data", data_o, 36'(0));
      check("rst_drop", 36'(drop_count), 36'(0));
      check("rst_debug", 36'(debug), 36'(0));
      reset = 1'b1;
      tick(1);
      check("disabled_dst_rdy", 36'(dst_rdy_o), 36'(0));
      set_reg(BASE_A, 32'd1);
      check("enabled_dst_rdy", 36'(dst_rdy_o), 36'(1));

      // good 10-word packet, output two cycles after EOF
      for (int k = 0; k < 10; k++) begin
         w = pw(k, 10, 8'h01, k == 9);
         expq.push_back(w);
         send_word(w);
         if (k == 0)
            check("pkt1_debug_open", 36'(debug), 36'h0_4000_0001);
      end
      check("pkt1_src_rdy_n1", 36'(src_rdy_o), 36'(0));
      check("pkt1_debug_commit", 36'(debug), 36'h0_0000_000A);
      tick(1);
      check("pkt1_src_rdy_n2", 36'(src_rdy_o), 36'(1));
      check("pkt1_first_word", data_o, expq[0]);
      drain_and_compare("pkt1");
      check("pkt1_drop", 36'(drop_count), 36'(0));

      // truncated packet, then a good one
      send_pkt(10, 7, 8'h02, 1'b1, 1'b0);
      tick(5);
      check("trunc_no_out", 36'(outq.size()), 36'(0));
      check("trunc_drop", 36'(drop_count), 36'(1));
      send_pkt(5, 5, 8'h03, 1'b1, 1'b1);
      drain_and_compare("pkt3");

      // stray words without SOF, then an interrupted packet
      send_word(mk(1'b0, 1'b0, 2'b00, 32'h1111_0000));
      check("nosof_drop", 36'(drop_count), 36'(2));
      check("nosof_debug", 36'(debug), 36'h0_8000_0000);
      send_word(mk(1'b0, 1'b1, 2'b00, 32'h1111_0001));
      check("nosof_idle", 36'(debug), 36'(0));
      send_pkt(6, 3, 8'h04, 1'b0, 1'b0);
      send_pkt(4, 4, 8'h05, 1'b1, 1'b1);
      check("interrupt_drop", 36'(drop_count), 36'(3));
      drain_and_compare("pkt5");

      // header length beyond buffer capacity
      send_word(pw(0, 20, 8'h06, 1'b0));
      check("oversize_drop", 36'(drop_count), 36'(4));
      check("oversize_debug", 36'(debug), 36'h0_8000_0000);
      rdy_all = 1'b1;
      for (int k = 1; k < 20; k++) begin
         rdy_all = rdy_all & dst_rdy_o;
         send_word(pw(k, 20, 8'h06, k == 19));
      end
      check("oversize_rdy_held", 36'(rdy_all), 36'(1));
      check("oversize_idle", 36'(debug), 36'(0));
      tick(4);
      check("oversize_no_out", 36'(outq.size()), 36'(0));

      // backpressure until full, then release across pointer wrap
      dst_rdy_i = 1'b0;
      send_pkt(8, 8, 8'h07, 1'b1, 1'b1);
      send_pkt(8, 8, 8'h08, 1'b1, 1'b1);
      data_i = pw(0, 8, 8'h09, 1'b0);
      src_rdy_i = 1'b1;
      tick(3);
      check("full_dst_rdy", 36'(dst_rdy_o), 36'(0));
      check("full_debug", 36'(debug), 36'h0_0000_000F);
      dst_rdy_i = 1'b1;
      send_pkt(8, 8, 8'h09, 1'b1, 1'b1);
      drain_and_compare("wrap");
      check("wrap_drop", 36'(drop_count), 36'(4));

      // saturation and counter clear
      for (int i = 0; i < 65540; i++)
         send_word(mk(1'b0, 1'b1, 2'b00, 32'(i)));
      check("sat_drop", 36'(drop_count), 36'h0_0000_FFFF);
      set_reg(BASE_A + 1, 32'd0);
      check("clr_drop", 36'(drop_count), 36'(0));
      check("clr_enable_kept", 36'(dst_rdy_o), 36'(1));

      // flush mid-packet with a committed packet waiting at the output
      send_word(mk(1'b0, 1'b1, 2'b00, 32'hDEAD_0000));
      check("pre_flush_drop", 36'(drop_count), 36'(1));
      dst_rdy_i = 1'b0;
      send_pkt(3, 3, 8'h0A, 1'b1, 1'b0);
      tick(3);
      check("pre_flush_src_rdy", 36'(src_rdy_o), 36'(1));
      send_pkt(5, 2, 8'h0B, 1'b0, 1'b0);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      check("flush_src_rdy", 36'(src_rdy_o), 36'(0));
      check("flush_debug", 36'(debug), 36'(0));
      check("flush_drop_kept", 36'(drop_count), 36'(1));
      check("flush_dst_rdy", 36'(dst_rdy_o), 36'(1));
      dst_rdy_i = 1'b1;
      send_pkt(2, 2, 8'h0C, 1'b1, 1'b1);
      drain_and_compare("post_flush");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
